// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the word-indexed PC, addresses the async ROM and
// fills the IF/ID register, honouring redirect > stall > fetch and halting past the ROM.
module if_stage #(
  parameter int N     = 32,
  parameter int Depth = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         redirect,
  input  logic [N-1:0] redirect_pc,
  output logic [N-1:0] rom_addr,
  input  logic [N-1:0] rom_instr,
  output logic [N-1:0] ifid_instr,
  output logic [N-1:0] ifid_pc,
  output logic         ifid_valid,
  output logic         halted,
  output logic [N-1:0] fetch_count
);

  typedef enum logic [1:0] {
    ACT_FETCH,
    ACT_HALT,
    ACT_HOLD,
    ACT_REDIRECT
  } action_e;

  localparam logic [N-1:0] DEPTH_N = N'(Depth);
  localparam logic [N-1:0] ONE_N   = N'(1);

  logic [N-1:0] pc_q,          pc_d;
  logic [N-1:0] ifid_instr_q,  ifid_instr_d;
  logic [N-1:0] ifid_pc_q,     ifid_pc_d;
  logic         ifid_valid_q,  ifid_valid_d;
  logic         halted_q,      halted_d;
  logic [N-1:0] fetch_count_q, fetch_count_d;

  action_e action;
  logic    pc_in_range;

  // The range check runs before the increment, so a redirect to 2^N-1 halts
  // instead of wrapping the PC back to 0.
  assign pc_in_range = (pc_q < DEPTH_N);

  always_comb begin
    if (redirect)         action = ACT_REDIRECT;
    else if (stall)       action = ACT_HOLD;
    else if (pc_in_range) action = ACT_FETCH;
    else                  action = ACT_HALT;
  end

  always_comb begin
    // NOTE: every next-state signal gets a hold default before the case, so no
    // path through the block leaves one unassigned and no latch is inferred.
    pc_d          = pc_q;
    ifid_instr_d  = ifid_instr_q;
    ifid_pc_d     = ifid_pc_q;
    ifid_valid_d  = ifid_valid_q;
    halted_d      = halted_q;
    fetch_count_d = fetch_count_q;
    unique case (action)
      ACT_REDIRECT: begin
        pc_d         = redirect_pc;
        ifid_instr_d = '0;
        ifid_pc_d    = '0;
        ifid_valid_d = 1'b0;
        halted_d     = 1'b0;
      end
      ACT_FETCH: begin
        pc_d          = pc_q + ONE_N;
        ifid_instr_d  = rom_instr;
        ifid_pc_d     = pc_q + ONE_N;
        ifid_valid_d  = 1'b1;
        fetch_count_d = fetch_count_q + ONE_N;
      end
      ACT_HALT: begin
        ifid_instr_d = '0;
        ifid_valid_d = 1'b0;
        halted_d     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values
    // regardless of statement order.
    if (reset) begin
      pc_q          <= '0;
      ifid_instr_q  <= '0;
      ifid_pc_q     <= '0;
      ifid_valid_q  <= 1'b0;
      halted_q      <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      ifid_instr_q  <= ifid_instr_d;
      ifid_pc_q     <= ifid_pc_d;
      ifid_valid_q  <= ifid_valid_d;
      halted_q      <= halted_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign rom_addr    = pc_q;
  assign ifid_instr  = ifid_instr_q;
  assign ifid_pc     = ifid_pc_q;
  assign ifid_valid  = ifid_valid_q;
  assign halted      = halted_q;
  assign fetch_count = fetch_count_q;

endmodule
